// File: rtl/osd_regaccess_arbiter_if.sv
// rtl/osd_regaccess_arbiter_if.sv - requester and register-target bus bundle for osd_regaccess_arbiter
//
// Purpose: carries the NREQ-wide requester side and the single register-target side
//          of the debug-module register-access arbiter.
// Modports:
//   master - arbiter view: takes requests and target responses, drives acks, reg_* and status
//   slave  - environment view: requesters plus register target
// Signals:
//   req_request/req_write/req_size [NREQ]   per-requester request, direction, size
//   req_addr   [NREQ*16]                    requester i at [16*i+:16]
//   req_wdata  [NREQ*DATA_WIDTH]            requester i at [DATA_WIDTH*i+:DATA_WIDTH]
//   req_ack/req_err [NREQ], req_rdata       response strobe, error, broadcast read data
//   reg_request/reg_write/reg_addr/reg_size/reg_wdata   latched access to the target
//   reg_ack/reg_err/reg_rdata               target completion
//   grant [NREQ], busy                      owner one-hot, transaction in progress
interface osd_regaccess_arbiter_if #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 16
);
    logic [NREQ-1:0]            req_request;
    logic [NREQ-1:0]            req_write;
    logic [NREQ*16-1:0]         req_addr;
    logic [NREQ-1:0]            req_size;
    logic [NREQ*DATA_WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            req_ack;
    logic [NREQ-1:0]            req_err;
    logic [DATA_WIDTH-1:0]      req_rdata;

    logic                       reg_request;
    logic                       reg_write;
    logic [15:0]                reg_addr;
    logic                       reg_size;
    logic [DATA_WIDTH-1:0]      reg_wdata;
    logic                       reg_ack;
    logic                       reg_err;
    logic [DATA_WIDTH-1:0]      reg_rdata;

    logic [NREQ-1:0]            grant;
    logic                       busy;

    modport master (
        input  req_request, req_write, req_addr, req_size, req_wdata,
        input  reg_ack, reg_err, reg_rdata,
        output req_ack, req_err, req_rdata,
        output reg_request, reg_write, reg_addr, reg_size, reg_wdata,
        output grant, busy
    );

    modport slave (
        output req_request, req_write, req_addr, req_size, req_wdata,
        output reg_ack, reg_err, reg_rdata,
        input  req_ack, req_err, req_rdata,
        input  reg_request, reg_write, reg_addr, reg_size, reg_wdata,
        input  grant, busy
    );
endinterface

// File: rtl/osd_regaccess_arbiter.sv
// rtl/osd_regaccess_arbiter.sv - round-robin arbiter sharing one register-access port among NREQ requesters
//
// Purpose: grants one requester at a time (round-robin from a rotating pointer), latches its
//          access onto the register-target port, and returns the response as a one-cycle
//          req_ack. A watchdog forces an error response if the target never acks.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset; abandons any transaction in flight
//   bus  - osd_regaccess_arbiter_if.master (requester side, register-target side, grant, busy)
// All outputs are registered.
module osd_regaccess_arbiter #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    osd_regaccess_arbiter_if.master bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Last BUSY count value before the watchdog fires; TIMEOUT cycles of BUSY in total.
    localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int CW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [IDXW-1:0]       r_ptr,         w_ptr_nxt;
    logic [IDXW-1:0]       r_owner,       w_owner_nxt;
    logic [CW-1:0]         r_cnt,         w_cnt_nxt;
    logic [NREQ-1:0]       r_grant,       w_grant_nxt;
    logic                  r_busy,        w_busy_nxt;
    logic                  r_reg_request, w_reg_request_nxt;
    logic                  r_reg_write,   w_reg_write_nxt;
    logic [15:0]           r_reg_addr,    w_reg_addr_nxt;
    logic                  r_reg_size,    w_reg_size_nxt;
    logic [DATA_WIDTH-1:0] r_reg_wdata,   w_reg_wdata_nxt;
    logic [NREQ-1:0]       r_req_ack,     w_req_ack_nxt;
    logic [NREQ-1:0]       r_req_err,     w_req_err_nxt;
    logic [DATA_WIDTH-1:0] r_req_rdata,   w_req_rdata_nxt;

    logic                  w_any;
    logic [IDXW-1:0]       w_win;
    logic [NREQ-1:0]       w_win_oh;

    // Round-robin search: first set request at or above the pointer, wrapping.
    always_comb begin : arb_search
        int idx;
        w_any = 1'b0;
        w_win = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_any && bus.req_request[idx]) begin
                w_any = 1'b1;
                w_win = IDXW'(idx);
            end
        end
    end

    always_comb begin
        w_win_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_win_oh[i] = (w_win == IDXW'(i));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_owner_nxt       = r_owner;
        w_cnt_nxt         = r_cnt;
        w_grant_nxt       = r_grant;
        w_busy_nxt        = r_busy;
        w_reg_request_nxt = r_reg_request;
        w_reg_write_nxt   = r_reg_write;
        w_reg_addr_nxt    = r_reg_addr;
        w_reg_size_nxt    = r_reg_size;
        w_reg_wdata_nxt   = r_reg_wdata;
        // Response outputs are pulses: zero unless this cycle launches RESP.
        w_req_ack_nxt     = '0;
        w_req_err_nxt     = '0;
        w_req_rdata_nxt   = '0;

        unique case (r_state)
            ST_IDLE: begin
                w_grant_nxt       = '0;
                w_busy_nxt        = 1'b0;
                w_reg_request_nxt = 1'b0;
                if (w_any) begin
                    w_state_nxt       = ST_BUSY;
                    w_owner_nxt       = w_win;
                    w_grant_nxt       = w_win_oh;
                    w_busy_nxt        = 1'b1;
                    w_reg_request_nxt = 1'b1;
                    w_cnt_nxt         = '0;
                    w_reg_write_nxt   = bus.req_write[w_win];
                    w_reg_addr_nxt    = bus.req_addr[16*int'(w_win) +: 16];
                    w_reg_size_nxt    = bus.req_size[w_win];
                    w_reg_wdata_nxt   = bus.req_wdata[DATA_WIDTH*int'(w_win) +: DATA_WIDTH];
                end
            end

            ST_BUSY: begin
                // An ack wins over a watchdog expiring in the same cycle.
                if (bus.reg_ack) begin
                    w_state_nxt       = ST_RESP;
                    w_reg_request_nxt = 1'b0;
                    w_req_ack_nxt     = r_grant;
                    w_req_err_nxt     = r_grant & {NREQ{bus.reg_err}};
                    w_req_rdata_nxt   = bus.reg_rdata;
                end else if ((TIMEOUT != 0) && (r_cnt == CW'(TMAX))) begin
                    w_state_nxt       = ST_RESP;
                    w_reg_request_nxt = 1'b0;
                    w_req_ack_nxt     = r_grant;
                    w_req_err_nxt     = r_grant;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
            end

            default: begin
                w_state_nxt       = ST_IDLE;
                w_grant_nxt       = '0;
                w_busy_nxt        = 1'b0;
                w_reg_request_nxt = 1'b0;
            end
        endcase
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr         <= '0;
            r_owner       <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_reg_request <= 1'b0;
            r_reg_write   <= 1'b0;
            r_reg_addr    <= '0;
            r_reg_size    <= 1'b0;
            r_reg_wdata   <= '0;
            r_req_ack     <= '0;
            r_req_err     <= '0;
            r_req_rdata   <= '0;
        end else begin
            r_ptr         <= w_ptr_nxt;
            r_owner       <= w_owner_nxt;
            r_cnt         <= w_cnt_nxt;
            r_grant       <= w_grant_nxt;
            r_busy        <= w_busy_nxt;
            r_reg_request <= w_reg_request_nxt;
            r_reg_write   <= w_reg_write_nxt;
            r_reg_addr    <= w_reg_addr_nxt;
            r_reg_size    <= w_reg_size_nxt;
            r_reg_wdata   <= w_reg_wdata_nxt;
            r_req_ack     <= w_req_ack_nxt;
            r_req_err     <= w_req_err_nxt;
            r_req_rdata   <= w_req_rdata_nxt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.busy        = r_busy;
    assign bus.reg_request = r_reg_request;
    assign bus.reg_write   = r_reg_write;
    assign bus.reg_addr    = r_reg_addr;
    assign bus.reg_size    = r_reg_size;
    assign bus.reg_wdata   = r_reg_wdata;
    assign bus.req_ack     = r_req_ack;
    assign bus.req_err     = r_req_err;
    assign bus.req_rdata   = r_req_rdata;

endmodule

// File: tb/tb_osd_regaccess_arbiter.sv
// tb/tb_osd_regaccess_arbiter.sv - directed self-checking bench for osd_regaccess_arbiter
module tb_osd_regaccess_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   hi_cnt;

    always #5 clk = ~clk;

    osd_regaccess_arbiter_if #(.NREQ(2), .DATA_WIDTH(16)) bus ();

    osd_regaccess_arbiter #(.NREQ(2), .DATA_WIDTH(16), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " reg_request"}, 32'(bus.reg_request), 32'h0);
        chk({tag, " grant"},       32'(bus.grant),       32'h0);
        chk({tag, " busy"},        32'(bus.busy),        32'h0);
        chk({tag, " req_ack"},     32'(bus.req_ack),     32'h0);
        chk({tag, " req_err"},     32'(bus.req_err),     32'h0);
        chk({tag, " req_rdata"},   32'(bus.req_rdata),   32'h0);
    endtask

    initial begin
        bus.req_request = '0;
        bus.req_write   = '0;
        bus.req_addr    = '0;
        bus.req_size    = '0;
        bus.req_wdata   = '0;
        bus.reg_ack     = 1'b0;
        bus.reg_err     = 1'b0;
        bus.reg_rdata   = '0;

        // Reset state
        step();
        step();
        chk_idle_outputs("reset");
        chk("reset reg_addr",  32'(bus.reg_addr),  32'h0);
        chk("reset reg_write", 32'(bus.reg_write), 32'h0);
        chk("reset reg_wdata", 32'(bus.reg_wdata), 32'h0);
        rst = 1'b0;

        // Single read by requester 0
        bus.req_request = 2'b01;
        bus.req_addr    = {16'h0000, 16'h0200};
        step();
        chk("rd busy reg_request", 32'(bus.reg_request), 32'h1);
        chk("rd busy reg_addr",    32'(bus.reg_addr),    32'h0200);
        chk("rd busy reg_write",   32'(bus.reg_write),   32'h0);
        chk("rd busy grant",       32'(bus.grant),       32'h1);
        chk("rd busy busy",        32'(bus.busy),        32'h1);
        chk("rd busy req_ack",     32'(bus.req_ack),     32'h0);
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 16'hBEEF;
        step();
        chk("rd resp req_ack",     32'(bus.req_ack),     32'h1);
        chk("rd resp req_rdata",   32'(bus.req_rdata),   32'hBEEF);
        chk("rd resp req_err",     32'(bus.req_err),     32'h0);
        chk("rd resp reg_request", 32'(bus.reg_request), 32'h0);
        chk("rd resp grant",       32'(bus.grant),       32'h1);
        chk("rd resp busy",        32'(bus.busy),        32'h1);
        bus.reg_ack     = 1'b0;
        bus.reg_rdata   = '0;
        bus.req_request = 2'b00;
        step();
        chk_idle_outputs("rd idle");

        // Contention after a fresh reset: 01, 10, 01
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        bus.req_request = 2'b11;
        bus.req_addr    = {16'h0110, 16'h0100};
        step();
        chk("ct1 grant",    32'(bus.grant),    32'h1);
        chk("ct1 reg_addr", 32'(bus.reg_addr), 32'h0100);
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 16'h1111;
        step();
        chk("ct1 req_ack",   32'(bus.req_ack),   32'h1);
        chk("ct1 req_rdata", 32'(bus.req_rdata), 32'h1111);
        bus.reg_ack = 1'b0;
        step();
        chk("ct1 idle grant", 32'(bus.grant), 32'h0);
        step();
        chk("ct2 grant",    32'(bus.grant),    32'h2);
        chk("ct2 reg_addr", 32'(bus.reg_addr), 32'h0110);
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 16'h2222;
        step();
        chk("ct2 req_ack",   32'(bus.req_ack),   32'h2);
        chk("ct2 req_rdata", 32'(bus.req_rdata), 32'h2222);
        bus.reg_ack = 1'b0;
        step();
        chk("ct2 idle grant", 32'(bus.grant), 32'h0);
        step();
        chk("ct3 grant", 32'(bus.grant), 32'h1);
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 16'h3333;
        step();
        chk("ct3 req_ack", 32'(bus.req_ack), 32'h1);
        bus.reg_ack     = 1'b0;
        bus.reg_rdata   = '0;
        bus.req_request = 2'b00;
        step();
        chk("ct3 idle req_rdata", 32'(bus.req_rdata), 32'h0);

        // Error passthrough on a write by requester 1
        bus.req_request = 2'b10;
        bus.req_write   = 2'b10;
        bus.req_addr    = {16'h0300, 16'h0000};
        bus.req_wdata   = {16'h1234, 16'h0000};
        step();
        chk("err grant",     32'(bus.grant),     32'h2);
        chk("err reg_write", 32'(bus.reg_write), 32'h1);
        chk("err reg_addr",  32'(bus.reg_addr),  32'h0300);
        chk("err reg_wdata", 32'(bus.reg_wdata), 32'h1234);
        bus.req_request = 2'b00;
        bus.reg_ack     = 1'b1;
        bus.reg_err     = 1'b1;
        bus.reg_rdata   = 16'h0055;
        step();
        chk("err req_ack", 32'(bus.req_ack), 32'h2);
        chk("err req_err", 32'(bus.req_err), 32'h2);
        bus.reg_ack   = 1'b0;
        bus.reg_err   = 1'b0;
        bus.reg_rdata = '0;
        bus.req_write = '0;
        step();
        chk_idle_outputs("err idle");

        // Timeout: target never acks
        bus.req_request = 2'b01;
        bus.req_addr    = {16'h0000, 16'h0400};
        step();
        hi_cnt = 0;
        for (int i = 0; i < 20 && bus.reg_request; i++) begin
            hi_cnt++;
            step();
        end
        chk("to reg_request cycles", 32'(hi_cnt), 32'd16);
        chk("to req_ack",   32'(bus.req_ack),   32'h1);
        chk("to req_err",   32'(bus.req_err),   32'h1);
        chk("to req_rdata", 32'(bus.req_rdata), 32'h0);
        bus.req_request = 2'b00;
        step();
        step();
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 16'h5555;
        step();
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = '0;
        chk("to late ack req_ack", 32'(bus.req_ack), 32'h0);
        chk("to late ack busy",    32'(bus.busy),    32'h0);
        step();
        chk("to late ack req_ack2", 32'(bus.req_ack), 32'h0);

        // Ack on the final BUSY cycle beats the watchdog
        bus.req_request = 2'b01;
        step();
        for (int i = 0; i < 15; i++) begin
            step();
        end
        chk("tie last busy reg_request", 32'(bus.reg_request), 32'h1);
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 16'h00AA;
        step();
        chk("tie req_ack",   32'(bus.req_ack),   32'h1);
        chk("tie req_err",   32'(bus.req_err),   32'h0);
        chk("tie req_rdata", 32'(bus.req_rdata), 32'h00AA);
        bus.reg_ack     = 1'b0;
        bus.reg_rdata   = '0;
        bus.req_request = 2'b00;
        step();

        // Reset mid-BUSY
        bus.req_request = 2'b01;
        step();
        chk("rst pre grant", 32'(bus.grant), 32'h1);
        bus.req_request = 2'b10;
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst async");
        step();
        chk("rst held req_ack", 32'(bus.req_ack), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("rst after grant",       32'(bus.grant),       32'h2);
        chk("rst after reg_request", 32'(bus.reg_request), 32'h1);
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 16'h0F0F;
        step();
        chk("rst after req_ack",   32'(bus.req_ack),   32'h2);
        chk("rst after req_rdata", 32'(bus.req_rdata), 32'h0F0F);
        bus.reg_ack     = 1'b0;
        bus.req_request = 2'b00;
        step();
        chk_idle_outputs("final idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
